chunked_rc_adder: RTL and testbench
===================================

CHUNKED_RC_ADDER -- requirements
Module: chunked_rc_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 2, meaning bits added per RUN cycle. WIDTH SHALL be a multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 The block SHALL have localparam N = WIDTH/CHUNK, meaning the number of RUN cycles per operation.
REQ-004 Clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Rst  in  1  reset; asynchronous and active-high.
REQ-006 Start  in  1  request a new addition; sampled only in IDLE or DONE.
REQ-007 A  in  WIDTH  first operand.
REQ-008 B  in  WIDTH  second operand.
REQ-009 Ci  in  1  carry-in.
REQ-010 Busy  out  1  high while state is RUN.
REQ-011 Done  out  1  one-cycle pulse; high while state is DONE.
REQ-012 S  out  WIDTH  registered sum.
REQ-013 Co  out  1  registered carry-out of the MSB.
REQ-014 Ovf  out  1  registered two's-complement overflow flag.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions as follows:
- IDLE -> RUN on Start.
- RUN -> DONE after N RUN cycles.
- DONE -> RUN on Start.
- DONE -> IDLE otherwise.
REQ-016 When Start is accepted at an edge, that edge SHALL do all of the following:
- capture A, B and Ci into internal registers;
- clear S, Co and Ovf to 0;
- reset the chunk index to 0.
REQ-017 Each RUN cycle SHALL add CHUNK bits [k*CHUNK +: CHUNK] of the captured operands plus the stored carry, for k = 0..N-1 in ascending order.
- The result is written into the same bit slice of S.
- The stored carry is updated with the chunk carry-out.
REQ-018 On the final chunk (k = N-1), the same edge SHALL set:
- Co = carry out of bit WIDTH-1;
- Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-019 Latency: if Start is accepted at edge t, Busy SHALL be high during cycles t..t+N-1 and Done SHALL be high during exactly the cycle following edge t+N.
REQ-020 Start while Busy SHALL be ignored, and changes on A, B or Ci during RUN SHALL NOT affect the result.
REQ-021 S, Co and Ovf SHALL be valid from Done assertion and SHALL hold until the next accepted Start.
REQ-022 Start high in the DONE cycle SHALL be accepted, giving back-to-back operations with no IDLE gap; Done still pulses for that cycle.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH with carry-out on Co. S, Co and Ovf SHALL equal A + B + Ci computed at full width.

Reset
REQ-024 Rst high SHALL immediately force all of the following, including mid-RUN, with the partial result discarded:
- state IDLE;
- Busy = 0, Done = 0;
- S = 0, Co = 0, Ovf = 0;
- captured operands, carry and chunk index = 0.
REQ-025 After Rst deasserts, the block SHALL accept Start at the first rising edge.

Structure
REQ-026 Shared package adder_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH and CHUNK constants.
REQ-027 A single sub-module fa_cell (1-bit full adder: S = A^B^Ci, Co = majority) SHALL be instantiated CHUNK times as a ripple chain per cycle; no other sub-modules.
REQ-028 All outputs SHALL be driven from registers; the combinational path SHALL be limited to one CHUNK-bit ripple chain.

Verification (WIDTH=8, CHUNK=2, N=4 unless stated)
REQ-029 A=0x0F, B=0x01, Ci=0 -> S=0x10, Co=0, Ovf=0, with Done high exactly 4 cycles after the Start edge.
REQ-030 A=0xFF, B=0x01, Ci=0 -> S=0x00, Co=1, Ovf=0; then A=0x7F, B=0x01, Ci=0 -> S=0x80, Co=0, Ovf=1.
REQ-031 A=0xFF, B=0xFF, Ci=1, with Start re-asserted in the DONE cycle and A=0x01, B=0x01, Ci=0 -> S=0xFF, Co=1, Ovf=0, then S=0x02, Co=0, Ovf=0, with no IDLE cycle between.
REQ-032 Start A=0x12, B=0x34, then during RUN hold Start high and change A=0xFF -> single operation only, S=0x46.
REQ-033 Rst pulsed after 2 RUN cycles -> Busy, Done, S, Co and Ovf = 0 immediately; next Start A=0x01, B=0x02 -> S=0x03.
REQ-034 Parameter sweep with CHUNK=1 and CHUNK=WIDTH (N=8 and N=1), using random operands against a full-width reference sum -> S, Co and Ovf match and Done latency is N.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and default sizing for the chunked ripple-carry adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHUNK = 2;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder, chained CHUNK times to form the per-cycle ripple.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/chunked_rc_adder.sv
// Multi-cycle adder: adds CHUNK bits per RUN cycle, LSB chunk first.
module chunked_rc_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [IW-1:0]    idx;
    logic             accept, last;
    logic [31:0]      off;
    logic [CHUNK-1:0] a_chunk, b_chunk, sum_c;
    logic [CHUNK:0]   c;

    assign accept  = Start && (state == IDLE || state == DONE);
    assign last    = (idx == IW'(N - 1));
    assign off     = 32'(idx) * CHUNK;
    assign a_chunk = CHUNK'(a_q >> off);
    assign b_chunk = CHUNK'(b_q >> off);
    assign c[0]    = carry;

    for (genvar i = 0; i < CHUNK; i++) begin : g_chain
        fa_cell u_fa (
            .a  (a_chunk[i]),
            .b  (b_chunk[i]),
            .ci (c[i]),
            .s  (sum_c[i]),
            .co (c[i+1])
        );
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (Start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = Start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Busy/Done are flopped from the next state so they come straight off registers.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_n;
            Busy  <= (state_n == RUN);
            Done  <= (state_n == DONE);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Co    <= 1'b0;
            Ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B;
            carry <= Ci;
            idx   <= '0;
            S     <= '0;
            Co    <= 1'b0;
            Ovf   <= 1'b0;
        end else if (state == RUN) begin
            S     <= (S & ~(MASK << off)) | (WIDTH'(sum_c) << off);
            carry <= c[CHUNK];
            idx   <= idx + IW'(1);
            if (last) begin
                Co  <= c[CHUNK];
                Ovf <= c[CHUNK-1] ^ c[CHUNK];
            end
        end
    end

endmodule

// File: tb/tb_chunked_rc_adder.sv
// Directed and random checks of chunked_rc_adder at CHUNK=2, 1 and WIDTH.
module tb_chunked_rc_adder;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ovf;
    } exp_t;

    logic       Clk;
    logic       Rst;
    logic [7:0] A, B;
    logic       Ci;
    logic       start_v [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic [7:0] s_v     [3];
    logic       co_v    [3];
    logic       ovf_v   [3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    chunked_rc_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .Clk(Clk), .Rst(Rst), .Start(start_v[0]), .A(A), .B(B), .Ci(Ci),
        .Busy(busy_v[0]), .Done(done_v[0]), .S(s_v[0]), .Co(co_v[0]), .Ovf(ovf_v[0])
    );

    chunked_rc_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .Clk(Clk), .Rst(Rst), .Start(start_v[1]), .A(A), .B(B), .Ci(Ci),
        .Busy(busy_v[1]), .Done(done_v[1]), .S(s_v[1]), .Co(co_v[1]), .Ovf(ovf_v[1])
    );

    chunked_rc_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .Clk(Clk), .Rst(Rst), .Start(start_v[2]), .A(A), .B(B), .Ci(Ci),
        .Busy(busy_v[2]), .Done(done_v[2]), .S(s_v[2]), .Co(co_v[2]), .Ovf(ovf_v[2])
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic int n_of(int d);
        return (d == 0) ? 4 : (d == 1) ? 8 : 1;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic start_op(int d, logic [7:0] a, logic [7:0] b, logic ci);
        exp_t       e;
        logic [8:0] full;
        full  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        e.s   = full[7:0];
        e.co  = full[8];
        e.ovf = (a[7] == b[7]) && (full[7] != a[7]);
        sb.push_back(e);
        A = a;
        B = b;
        Ci = ci;
        start_v[d] = 1'b1;
    endtask

    task automatic launch(int d);
        @(posedge Clk);
        @(negedge Clk);
        start_v[d] = 1'b0;
        check("busy_after_start", busy_v[d], 1);
    endtask

    task automatic finish_op(int d, int lat);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (!done_v[d] && cyc < 40) begin
            @(posedge Clk);
            @(negedge Clk);
            cyc++;
        end
        check("latency", cyc, lat);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            e = sb.pop_front();
            check("sum", s_v[d], e.s);
            check("carry_out", co_v[d], e.co);
            check("overflow", ovf_v[d], e.ovf);
        end
    endtask

    initial begin
        Rst = 1'b1;
        A = '0;
        B = '0;
        Ci = 1'b0;
        for (int i = 0; i < 3; i++) start_v[i] = 1'b0;

        @(negedge Clk);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_s", s_v[0], 0);
        check("rst_co", co_v[0], 0);
        check("rst_ovf", ovf_v[0], 0);

        // First edge after reset release must accept Start.
        Rst = 1'b0;
        start_op(0, 8'h0F, 8'h01, 1'b0);
        launch(0);
        finish_op(0, 4);
        @(posedge Clk);
        @(negedge Clk);
        check("done_one_cycle", done_v[0], 0);
        check("idle_busy", busy_v[0], 0);
        check("s_hold", s_v[0], 8'h10);

        start_op(0, 8'hFF, 8'h01, 1'b0);
        launch(0);
        finish_op(0, 4);
        @(negedge Clk);
        start_op(0, 8'h7F, 8'h01, 1'b0);
        launch(0);
        finish_op(0, 4);
        @(negedge Clk);

        start_op(0, 8'hFF, 8'hFF, 1'b1);
        launch(0);
        finish_op(0, 4);
        start_op(0, 8'h01, 8'h01, 1'b0);
        launch(0);
        finish_op(0, 4);
        @(negedge Clk);

        // Start held and A changed while running must not disturb the sum.
        start_op(0, 8'h12, 8'h34, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        A = 8'hFF;
        check("busy_run", busy_v[0], 1);
        @(posedge Clk);
        @(negedge Clk);
        start_v[0] = 1'b0;
        finish_op(0, 3);
        @(posedge Clk);
        @(negedge Clk);
        check("single_op_busy", busy_v[0], 0);
        check("single_op_done", done_v[0], 0);

        start_op(0, 8'h55, 8'h55, 1'b0);
        launch(0);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("midrst_busy", busy_v[0], 0);
        check("midrst_done", done_v[0], 0);
        check("midrst_s", s_v[0], 0);
        check("midrst_co", co_v[0], 0);
        check("midrst_ovf", ovf_v[0], 0);
        void'(sb.pop_back());
        @(negedge Clk);
        Rst = 1'b0;
        start_op(0, 8'h01, 8'h02, 1'b0);
        launch(0);
        finish_op(0, 4);
        @(negedge Clk);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 6; i++) begin
                start_op(d, 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)),
                         1'($urandom_range(0, 1)));
                launch(d);
                finish_op(d, n_of(d));
                @(negedge Clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
